// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU ROM sequencer: FSM state encoding, op codes
// common with the ROM image generator, and default timing parameters.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEFAULT_SETTLE_CYCLES = 4;
    localparam int DEFAULT_CNT_W         = 3;

    // Op codes must match the table layout burned into both nibble ROMs
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_AND    = 4'h2;
    localparam logic [3:0] OP_OR     = 4'h3;
    localparam logic [3:0] OP_XOR    = 4'h4;
    localparam logic [3:0] OP_PASS_A = 4'h5;
    localparam logic [3:0] OP_PASS_B = 4'h6;
    localparam logic [3:0] OP_SHL    = 4'h7;

    function automatic bit settle_fits(input int settle_cycles, input int cnt_w);
        return (settle_cycles >= 1) && ((1 << cnt_w) > settle_cycles);
    endfunction

endpackage

// File: rtl/alu_settle_timer.sv
// Down-counter that times the ROM access window; loads, decrements without
// wrapping, and flags when it has reached zero.
module alu_settle_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             is_zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign is_zero = (count == '0);

endmodule

// File: rtl/alu_seq.sv
// Sequencer for the two nibble ALU ROMs: latches operands, holds n_oe low for
// the EEPROM access time, then captures the result and flags.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] op,
    input  logic       invert,
    input  logic       carry_in,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    output logic       alu_invert,
    output logic       alu_carry_in,
    output logic       alu_n_oe,
    input  logic [7:0] alu_res,
    input  logic       alu_n_carry
);

    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(SETTLE_CYCLES - 1);

    state_t state;
    state_t state_next;
    logic   accept;
    logic   timer_zero;

    assign accept = (state == ST_IDLE) && start;

    alu_settle_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_value(LOAD_VALUE),
        .dec       (state == ST_SETTLE),
        .is_zero   (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Starts arriving outside IDLE are dropped, never queued
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_SETTLE;
            ST_SETTLE:  if (timer_zero) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // ROM address/control regs freeze for the whole access; n_oe released at capture
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            alu_op       <= 4'h0;
            alu_invert   <= 1'b0;
            alu_carry_in <= 1'b0;
            alu_n_oe     <= 1'b1;
            result       <= 8'h00;
            carry        <= 1'b0;
            zero         <= 1'b0;
        end else begin
            if (accept) begin
                alu_a        <= a_in;
                alu_b        <= b_in;
                alu_op       <= op;
                alu_invert   <= invert;
                alu_carry_in <= carry_in;
                alu_n_oe     <= 1'b0;
            end
            if (state == ST_CAPTURE) begin
                result   <= alu_res;
                carry    <= ~alu_n_carry;
                zero     <= (alu_res == 8'h00);
                alu_n_oe <= 1'b1;
            end
        end
    end

    assign busy = (state == ST_SETTLE) || (state == ST_CAPTURE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural adder ROM stub (350 ns data
// delay, n_oe gated) on a 100 ns clock.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int SETTLE = 4;
    localparam int CNTW   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] op;
    logic       invert;
    logic       carry_in;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic       alu_invert;
    logic       alu_carry_in;
    logic       alu_n_oe;
    logic [7:0] rom_res;
    logic       rom_n_carry;
    logic [8:0] rom_sum;

    int tests = 0;
    int fails = 0;
    int cyc;
    int dones;
    int idx;
    int prev_idx;

    alu_seq #(
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (CNTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .invert      (invert),
        .carry_in    (carry_in),
        .a_in        (a_in),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .carry       (carry),
        .zero        (zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_invert  (alu_invert),
        .alu_carry_in(alu_carry_in),
        .alu_n_oe    (alu_n_oe),
        .alu_res     (rom_res),
        .alu_n_carry (rom_n_carry)
    );

    always #50 clk = ~clk;

    // Adder ROM pair: data appears 350 ns after address or n_oe changes
    always @(alu_a or alu_b or alu_carry_in or alu_n_oe) begin
        rom_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
        if (alu_n_oe) begin
            rom_res     <= #350 8'hxx;
            rom_n_carry <= #350 1'bx;
        end else begin
            rom_res     <= #350 rom_sum[7:0];
            rom_n_carry <= #350 ~rom_sum[8];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task tick();
        @(negedge clk);
    endtask

    task applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin);
        a_in     = a;
        b_in     = b;
        carry_in = cin;
        op       = OP_ADD;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task waitDone(output int n);
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        op       = 4'h0;
        invert   = 1'b0;
        carry_in = 1'b0;
        a_in     = 8'h00;
        b_in     = 8'h00;

        // Reset
        tick();
        tick();
        checkOutput("reset_result", 32'(result), 32'h00);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_n_oe", 32'(alu_n_oe), 32'h1);
        checkOutput("reset_carry_zero", 32'({carry, zero}), 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("idle_n_oe", 32'(alu_n_oe), 32'h1);

        // Basic add 3C + 05
        applyStimulus(8'h3C, 8'h05, 1'b0);
        checkOutput("add_busy", 32'(busy), 32'h1);
        checkOutput("add_n_oe_low", 32'(alu_n_oe), 32'h0);
        checkOutput("add_alu_a", 32'(alu_a), 32'h3C);
        checkOutput("add_alu_op", 32'(alu_op), 32'(OP_ADD));
        waitDone(cyc);
        checkOutput("add_latency", 32'(cyc + 1), 32'(SETTLE + 2));
        checkOutput("add_result", 32'(result), 32'h41);
        checkOutput("add_carry_zero", 32'({carry, zero}), 32'h0);
        checkOutput("add_done_busy", 32'(busy), 32'h0);
        checkOutput("add_done_n_oe", 32'(alu_n_oe), 32'h1);
        tick();
        checkOutput("add_done_pulse", 32'(done), 32'h0);

        // Carry and zero: FF + 01
        applyStimulus(8'hFF, 8'h01, 1'b0);
        waitDone(cyc);
        checkOutput("cz_result", 32'(result), 32'h00);
        checkOutput("cz_carry", 32'(carry), 32'h1);
        checkOutput("cz_zero", 32'(zero), 32'h1);
        tick();

        // Carry in: 10 + 20 + 1
        applyStimulus(8'h10, 8'h20, 1'b1);
        checkOutput("cin_latched", 32'(alu_carry_in), 32'h1);
        checkOutput("cin_alu_b", 32'(alu_b), 32'h20);
        waitDone(cyc);
        checkOutput("cin_result", 32'(result), 32'h31);
        checkOutput("cin_carry_zero", 32'({carry, zero}), 32'h0);
        tick();

        // Start and operand change while busy
        applyStimulus(8'h3C, 8'h05, 1'b0);
        tick();
        start = 1'b1;
        a_in  = 8'h77;
        tick();
        start = 1'b0;
        checkOutput("busy_alu_a_frozen", 32'(alu_a), 32'h3C);
        checkOutput("busy_still_busy", 32'(busy), 32'h1);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checkOutput("busy_single_done", 32'(dones), 32'h1);
        checkOutput("busy_result", 32'(result), 32'h41);

        // Reset during the second SETTLE cycle
        applyStimulus(8'h12, 8'h34, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_n_oe", 32'(alu_n_oe), 32'h1);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_result", 32'(result), 32'h00);
        checkOutput("abort_alu_a", 32'(alu_a), 32'h00);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checkOutput("abort_no_done", 32'(dones), 32'h0);

        // Back-to-back with start held high
        a_in     = 8'h01;
        b_in     = 8'h02;
        carry_in = 1'b0;
        start    = 1'b1;
        dones    = 0;
        idx      = 0;
        prev_idx = 0;
        while (dones < 3 && idx < 60) begin
            tick();
            idx++;
            if (done === 1'b1) begin
                if (dones == 0)
                    checkOutput("b2b_first_latency", 32'(idx), 32'(SETTLE + 2));
                else
                    checkOutput("b2b_interval", 32'(idx - prev_idx), 32'(SETTLE + 3));
                prev_idx = idx;
                dones++;
            end
        end
        start = 1'b0;
        checkOutput("b2b_done_count", 32'(dones), 32'h3);
        checkOutput("b2b_result", 32'(result), 32'h03);
        tick();
        checkOutput("b2b_done_dropped", 32'(done), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
